// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: per-lane register-file writes, HI/LO and LL-bit
// writeback, with flush, bubble and hold handling and a retired-instruction
// counter. Every output is driven directly from a flop.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_mem,
    input  logic                      stall_wb,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [LANES*DATA_W-1:0]   wdata,
    input  logic [LANES*ADDR_W-1:0]   waddr,
    input  logic [LANES-1:0]          wr_en,
    input  logic [DATA_W-1:0]         hi_i,
    input  logic [DATA_W-1:0]         lo_i,
    input  logic                      whilo,
    input  logic                      llbit_we,
    input  logic                      llbit_val,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic [LANES*ADDR_W-1:0]   wb_waddr,
    output logic [LANES-1:0]          wb_wr_en,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_whilo,
    output logic                      wb_llbit_we,
    output logic                      wb_llbit_val,
    output logic                      wb_valid,
    output logic [31:0]               retire_cnt
);

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_CAPTURE
    } action_t;

    action_t            action;
    logic [LANES-1:0]   lane_nz;
    logic [LANES-1:0]   cap_wr_en;

    // Writes to register 0 are architecturally discarded, so flag non-zero destinations.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_nz[k] = |waddr[k*ADDR_W +: ADDR_W];
    end

    // Lane enables as they would be captured: gated by a real instruction and a non-zero address.
    always_comb begin
        cap_wr_en = wr_en & lane_nz & {LANES{in_valid}};
    end

    // Pick the single action for this cycle: reset > flush > bubble > hold > capture.
    always_comb begin
        action = ACT_CAPTURE;
        if (rst)
            action = ACT_RESET;
        else if (flush)
            action = ACT_FLUSH;
        else if (stall_mem && !stall_wb)
            action = ACT_BUBBLE;
        else if (stall_wb)
            action = ACT_HOLD;
    end

    // Writeback register update; flush and bubble both load an all-zero slot but keep the count.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                wb_wdata     <= '0;
                wb_waddr     <= '0;
                wb_wr_en     <= '0;
                wb_hi        <= '0;
                wb_lo        <= '0;
                wb_whilo     <= 1'b0;
                wb_llbit_we  <= 1'b0;
                wb_llbit_val <= 1'b0;
                wb_valid     <= 1'b0;
                if (action == ACT_RESET)
                    retire_cnt <= '0;
            end
            ACT_CAPTURE: begin
                wb_wdata     <= wdata;
                wb_waddr     <= waddr;
                wb_wr_en     <= cap_wr_en;
                wb_hi        <= hi_i;
                wb_lo        <= lo_i;
                wb_whilo     <= whilo & in_valid;
                wb_llbit_we  <= llbit_we & in_valid;
                wb_llbit_val <= llbit_val;
                wb_valid     <= in_valid;
                if (in_valid)
                    retire_cnt <= retire_cnt + 32'd1;
            end
            default: begin
                // hold: every output keeps its value
            end
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: directed scenarios followed by random traffic,
// checked against an action-level reference model. Runs a 1-lane and a 2-lane
// instance side by side from shared stimulus.
module tb_mem_wb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_mem, stall_wb, flush, in_valid;
    logic [63:0] wdata;
    logic [9:0]  waddr;
    logic [1:0]  wr_en;
    logic [31:0] hi_i, lo_i;
    logic        whilo, llbit_we, llbit_val;

    logic [31:0] wb_wdata1;
    logic [4:0]  wb_waddr1;
    logic [0:0]  wb_wr_en1;
    logic [31:0] wb_hi1, wb_lo1, cnt1;
    logic        wb_whilo1, wb_llwe1, wb_llval1, wb_valid1;

    logic [63:0] wb_wdata2;
    logic [9:0]  wb_waddr2;
    logic [1:0]  wb_wr_en2;
    logic [31:0] wb_hi2, wb_lo2, cnt2;
    logic        wb_whilo2, wb_llwe2, wb_llval2, wb_valid2;

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush(flush), .in_valid(in_valid),
        .wdata(wdata[31:0]), .waddr(waddr[4:0]), .wr_en(wr_en[0:0]),
        .hi_i(hi_i), .lo_i(lo_i), .whilo(whilo),
        .llbit_we(llbit_we), .llbit_val(llbit_val),
        .wb_wdata(wb_wdata1), .wb_waddr(wb_waddr1), .wb_wr_en(wb_wr_en1),
        .wb_hi(wb_hi1), .wb_lo(wb_lo1), .wb_whilo(wb_whilo1),
        .wb_llbit_we(wb_llwe1), .wb_llbit_val(wb_llval1),
        .wb_valid(wb_valid1), .retire_cnt(cnt1)
    );

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2)) dut2 (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush(flush), .in_valid(in_valid),
        .wdata(wdata), .waddr(waddr), .wr_en(wr_en),
        .hi_i(hi_i), .lo_i(lo_i), .whilo(whilo),
        .llbit_we(llbit_we), .llbit_val(llbit_val),
        .wb_wdata(wb_wdata2), .wb_waddr(wb_waddr2), .wb_wr_en(wb_wr_en2),
        .wb_hi(wb_hi2), .wb_lo(wb_lo2), .wb_whilo(wb_whilo2),
        .wb_llbit_we(wb_llwe2), .wb_llbit_val(wb_llval2),
        .wb_valid(wb_valid2), .retire_cnt(cnt2)
    );

    int unsigned compares = 0;
    int unsigned fails = 0;

    // Reference model state: what the WB slot should hold as an instruction record.
    logic [31:0] m_data [2];
    logic [4:0]  m_addr [2];
    logic        m_we   [2];
    logic [31:0] m_hi, m_lo;
    logic        m_whilo, m_llwe, m_llval, m_valid;
    logic [31:0] m_cnt1, m_cnt2;

    task automatic model_empty_slot();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 32'd0;
            m_addr[i] = 5'd0;
            m_we[i]   = 1'b0;
        end
        m_hi = 32'd0; m_lo = 32'd0;
        m_whilo = 1'b0; m_llwe = 1'b0; m_llval = 1'b0; m_valid = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour from the rule list.
    task automatic model_edge();
        if (rst) begin
            model_empty_slot();
            m_cnt1 = 32'd0;
            m_cnt2 = 32'd0;
        end else if (flush || (stall_mem && !stall_wb)) begin
            model_empty_slot();
        end else if (!stall_wb) begin
            for (int i = 0; i < 2; i++) begin
                m_data[i] = wdata[i*32 +: 32];
                m_addr[i] = waddr[i*5 +: 5];
                m_we[i]   = in_valid && wr_en[i] && (m_addr[i] != 5'd0);
            end
            m_hi    = hi_i;
            m_lo    = lo_i;
            m_whilo = in_valid && whilo;
            m_llwe  = in_valid && llbit_we;
            m_llval = llbit_val;
            m_valid = in_valid;
            if (in_valid) begin
                m_cnt1 = m_cnt1 + 32'd1;
                m_cnt2 = m_cnt2 + 32'd1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("l1_wdata",  64'(wb_wdata1), 64'(m_data[0]));
        check("l1_waddr",  64'(wb_waddr1), 64'(m_addr[0]));
        check("l1_wr_en",  64'(wb_wr_en1), 64'(m_we[0]));
        check("l1_hi",     64'(wb_hi1),    64'(m_hi));
        check("l1_lo",     64'(wb_lo1),    64'(m_lo));
        check("l1_whilo",  64'(wb_whilo1), 64'(m_whilo));
        check("l1_llwe",   64'(wb_llwe1),  64'(m_llwe));
        check("l1_llval",  64'(wb_llval1), 64'(m_llval));
        check("l1_valid",  64'(wb_valid1), 64'(m_valid));
        check("l1_cnt",    64'(cnt1),      64'(m_cnt1));
        check("l2_wdata",  wb_wdata2,      {m_data[1], m_data[0]});
        check("l2_waddr",  64'(wb_waddr2), 64'({m_addr[1], m_addr[0]}));
        check("l2_wr_en",  64'(wb_wr_en2), 64'({m_we[1], m_we[0]}));
        check("l2_hilo",   {wb_hi2, wb_lo2}, {m_hi, m_lo});
        check("l2_flags",  64'({wb_whilo2, wb_llwe2, wb_llval2, wb_valid2}),
                           64'({m_whilo, m_llwe, m_llval, m_valid}));
        check("l2_cnt",    64'(cnt2),      64'(m_cnt2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0; in_valid = 1'b0;
        wdata = 64'd0; waddr = 10'd0; wr_en = 2'b00;
        hi_i = 32'd0; lo_i = 32'd0; whilo = 1'b0; llbit_we = 1'b0; llbit_val = 1'b0;
    endtask

    initial begin
        model_empty_slot();
        m_cnt1 = 32'd0;
        m_cnt2 = 32'd0;
        idle_inputs();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_cnt", 64'(cnt1), 64'd0);
        check("rst_valid", 64'(wb_valid2), 64'd0);

        // Basic capture, one-cycle latency
        idle_inputs();
        in_valid = 1'b1; wr_en = 2'b11;
        wdata = {32'hCAFE_0001, 32'h1234_5678};
        waddr = {5'd7, 5'd3};
        hi_i = 32'hAAAA_0001; lo_i = 32'h5555_0002; whilo = 1'b1;
        llbit_we = 1'b1; llbit_val = 1'b1;
        tick();
        check("cap_wdata", 64'(wb_wdata1), 64'h1234_5678);
        check("cap_waddr", 64'(wb_waddr1), 64'd3);
        check("cap_wr_en", 64'(wb_wr_en1), 64'd1);
        check("cap_valid", 64'(wb_valid1), 64'd1);
        check("cap_cnt",   64'(cnt1),      64'd1);

        // Destination register 0 suppresses the write but still retires
        waddr = {5'd9, 5'd0}; wdata = {32'h0BAD_0BAD, 32'h0000_00FF};
        tick();
        check("r0_wr_en", 64'(wb_wr_en1), 64'd0);
        check("r0_valid", 64'(wb_valid1), 64'd1);
        check("r0_cnt",   64'(cnt1),      64'd2);

        // Hold for three cycles, then a bubble
        stall_mem = 1'b1; stall_wb = 1'b1;
        wdata = {32'h1111_1111, 32'h2222_2222}; waddr = {5'd1, 5'd2};
        repeat (3) tick();
        check("hold_cnt",  64'(cnt1),      64'd2);
        check("hold_data", 64'(wb_wdata1), 64'h0000_00FF);
        stall_wb = 1'b0;
        tick();
        check("bub_valid", 64'(wb_valid1), 64'd0);
        check("bub_whilo", 64'(wb_whilo2), 64'd0);
        check("bub_cnt",   64'(cnt2),      64'd2);

        // Flush wins over stall_wb and discards a valid instruction
        idle_inputs();
        in_valid = 1'b1; wr_en = 2'b11; waddr = {5'd5, 5'd6};
        wdata = {32'h3333_3333, 32'h4444_4444};
        whilo = 1'b1; flush = 1'b1; stall_wb = 1'b1;
        tick();
        check("fl_whilo", 64'(wb_whilo1), 64'd0);
        check("fl_valid", 64'(wb_valid1), 64'd0);
        check("fl_cnt",   64'(cnt1),      64'd2);

        // Two lanes writing the same address are both passed through
        idle_inputs();
        in_valid = 1'b1; wr_en = 2'b11;
        waddr = {5'd4, 5'd4};
        wdata = {32'h0000_000B, 32'h0000_000A};
        tick();
        check("dual_wdata", wb_wdata2, {32'h0000_000B, 32'h0000_000A});
        check("dual_waddr", 64'(wb_waddr2), 64'({5'd4, 5'd4}));
        check("dual_wr_en", 64'(wb_wr_en2), 64'd3);

        // Reset during a hold clears the held instruction
        stall_wb = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rsthold_wdata", wb_wdata2, 64'd0);
        check("rsthold_wr_en", 64'(wb_wr_en2), 64'd0);
        check("rsthold_cnt",   64'(cnt2), 64'd0);

        // First capture after reset is ordinary
        idle_inputs();
        in_valid = 1'b1; wr_en = 2'b01; waddr = {5'd0, 5'd12};
        wdata = {32'd0, 32'hDEAD_BEEF};
        tick();
        check("post_rst_cnt", 64'(cnt1), 64'd1);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut1.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut1.retire_cnt;
        m_cnt1 = 32'hFFFF_FFFF;
        tick();
        check("wrap_cnt", 64'(cnt1), 64'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(39) == 0);
            flush     = ($urandom_range(9) == 0);
            stall_mem = ($urandom_range(3) == 0);
            stall_wb  = ($urandom_range(3) == 0);
            in_valid  = ($urandom_range(3) != 0);
            wdata     = {$urandom, $urandom};
            for (int l = 0; l < 2; l++)
                waddr[l*5 +: 5] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
            wr_en     = 2'($urandom_range(3));
            hi_i      = $urandom;
            lo_i      = $urandom;
            whilo     = ($urandom_range(1) == 1);
            llbit_we  = ($urandom_range(1) == 1);
            llbit_val = ($urandom_range(1) == 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register-file write-data width per lane.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width per lane.
REQ-003 Parameter LANES, default 1, range 1..4, SHALL set the number of independent register-file write lanes.
REQ-004 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 stall_mem  in  1  SHALL indicate that the MEM stage is stalled.
REQ-007 stall_wb  in  1  SHALL indicate that the WB stage is stalled.
REQ-008 flush  in  1  SHALL indicate an exception/pipeline flush request.
REQ-009 in_valid  in  1  SHALL mark the MEM-stage slot as holding a real instruction.
REQ-010 wdata  in  LANES*DATA_W  SHALL carry per-lane write data, with lane k at bits [k*DATA_W +: DATA_W].
REQ-011 waddr  in  LANES*ADDR_W  SHALL carry per-lane destination addresses, packed like wdata.
REQ-012 wr_en  in  LANES  SHALL carry per-lane write enables.
REQ-013 hi_i, lo_i  in  DATA_W each  SHALL carry HI/LO write values; whilo  in  1  SHALL be the HI/LO write enable.
REQ-014 llbit_we, llbit_val  in  1 each  SHALL carry the LL-bit write request and value.
REQ-015 wb_wdata, wb_waddr, wb_wr_en  out  same widths as inputs  SHALL be registered per-lane writeback outputs.
REQ-016 wb_hi, wb_lo (DATA_W), wb_whilo, wb_llbit_we, wb_llbit_val (1)  out  SHALL be registered HI/LO and LL-bit outputs.
REQ-017 wb_valid  out  1  SHALL mark the WB slot as holding a real instruction.
REQ-018 retire_cnt  out  32  SHALL count valid instructions captured into WB.

Function
REQ-019 Each cycle the block SHALL take exactly one action, in priority order: reset > flush > bubble > hold > capture.
REQ-020 Flush (flush=1) SHALL load a bubble regardless of either stall.
REQ-021 Bubble (stall_mem=1, stall_wb=0) SHALL load all-zero data, addresses, enables and wb_valid=0.
REQ-022 Hold (stall_wb=1) SHALL keep every output unchanged, including retire_cnt.
REQ-023 Capture (stall_mem=0, stall_wb=0) SHALL register all inputs with one-cycle latency.
REQ-024 On capture, lane k's wb_wr_en[k] SHALL be forced to 0 when waddr lane k equals 0; its address and data SHALL still be registered.
REQ-025 On capture with in_valid=0, every enable output (wb_wr_en, wb_whilo, wb_llbit_we) SHALL be forced to 0, and wb_valid SHALL be 0.
REQ-026 retire_cnt SHALL increment by 1 only on a capture with in_valid=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 Flush in the same cycle as a valid input SHALL discard that input, with no retire_cnt increment.
REQ-028 Lanes SHALL be independent; there is no cross-lane address arbitration (the downstream register file resolves same-address writes in favour of the highest lane).
REQ-029 The block SHALL be purely registered: no combinational path from any input to any output.

Reset
REQ-030 While rst=1 at a clock edge, all data and address outputs SHALL go to 0, all enables to 0, wb_valid to 0, and retire_cnt to 0.
REQ-031 Reset SHALL override flush and both stalls, and SHALL abort any held instruction mid-stall.
REQ-032 The first capture after rst deasserts SHALL behave as a normal capture.

Verification
REQ-033 LANES=1, capture of wdata=0x12345678, waddr=3, wr_en=1, in_valid=1 -> next cycle wb_wdata=0x12345678, wb_waddr=3, wb_wr_en=1, wb_valid=1, retire_cnt=1.
REQ-034 waddr=0, wr_en=1, in_valid=1 -> wb_wr_en=0, wb_valid=1, retire_cnt increments.
REQ-035 stall_mem=1, stall_wb=1 for 3 cycles, then stall_mem=1, stall_wb=0 -> outputs hold for 3 cycles, then a bubble (all enables 0, wb_valid=0), and retire_cnt unchanged throughout.
REQ-036 flush=1 with stall_wb=1 and valid input whilo=1 -> bubble, wb_whilo=0, no increment.
REQ-037 Preload retire_cnt to 0xFFFFFFFF by forcing, then one valid capture -> retire_cnt=0.
REQ-038 LANES=2, lane0 (addr 4, 0xA), lane1 (addr 4, 0xB), both enabled -> both lanes are registered unchanged with both enables 1; rst=1 during a hold -> all outputs go to 0 on the next edge.
